bram_seq: RTL

- Command sequencer that sits directly upstream of the 256x8 block RAM and owns its single port (data, readWrite, addr); it also consumes the RAM's registered read output.
- Accepts one command at a time over a start/busy/done handshake. Commands are FILL, SUM and FIND over a contiguous, wrap-around address range.
- Results are returned on a 16-bit result bus plus a found flag. Used by the top level to initialise, checksum and search RAM contents without per-cycle host control.

---
 rtl/bram_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bram_seq.sv
// Command sequencer owning the single port of a 256x8 block RAM: FILL, SUM and FIND over a wrap-around range.
// Optional macro BRAM_SEQ_VERIFY_EN: FILL re-reads its range and reports the mismatch count.
module bram_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  result,
    output logic              found,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t              state, state_nx;
    logic [1:0]          op_r;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     idx;
    logic [DATA_W-1:0]   key_r;
    logic                vld_pipe;
    logic [ADDR_W-1:0]   addr_d;
    logic                last, hit, is_fill, is_find, accept;

    assign is_fill = (op_r == 2'b00);
    assign is_find = (op_r == 2'b10);
    assign last    = (idx == len_r - 1'b1);
    assign hit     = vld_pipe && is_find && (mem_rdata == key_r);
    assign accept  = (state == IDLE) && start;

    // Address wraps naturally by truncation; idx is left at its final value so an idle port holds its address.
    assign mem_addr = base_r + idx[ADDR_W-1:0];
    assign mem_rw   = (state == WRITE);
    assign mem_data = (state == WRITE) ? key_r : '0;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)          state_nx = DONE;
                    else if (op == 2'b00)   state_nx = WRITE;
                    else                    state_nx = READ;
                end
            end
            WRITE: begin
                if (last) begin
`ifdef BRAM_SEQ_VERIFY_EN
                    state_nx = READ;
`else
                    state_nx = DONE;
`endif
                end
            end
            READ: begin
                if (hit)        state_nx = DONE;
                else if (last)  state_nx = DRAIN;
            end
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= '0;
            base_r   <= '0;
            len_r    <= '0;
            key_r    <= '0;
            idx      <= '0;
            vld_pipe <= 1'b0;
            addr_d   <= '0;
            result   <= '0;
            found    <= 1'b0;
        end else begin
            state    <= state_nx;
            // A FIND hit flushes the word still in flight.
            vld_pipe <= (state == READ) && !hit;
            addr_d   <= mem_addr;

            if ((state == WRITE || state == READ) && !last)
                idx <= idx + 1'b1;
`ifdef BRAM_SEQ_VERIFY_EN
            if (state == WRITE && last)
                idx <= '0;
`endif

            if (vld_pipe) begin
                if (is_find) begin
                    if (mem_rdata == key_r) begin
                        found  <= 1'b1;
                        result <= {{(SUM_W-ADDR_W){1'b0}}, addr_d};
                    end
                end
`ifdef BRAM_SEQ_VERIFY_EN
                else if (is_fill) begin
                    result <= result + {{(SUM_W-1){1'b0}}, (mem_rdata != key_r)};
                end
`endif
                else if (!is_fill) begin
                    result <= result + {{(SUM_W-DATA_W){1'b0}}, mem_rdata};
                end
            end

            if (accept) begin
                op_r   <= op;
                len_r  <= len;
                key_r  <= fill_data;
                result <= '0;
                found  <= 1'b0;
                if (len != '0) begin
                    base_r <= base;
                    idx    <= '0;
                end
            end
        end
    end

endmodule
